// File: rtl/reset_sequencer_pkg.sv
// Shared types and helpers for the reset sequencer (package rstseq_pkg).
// State encoding is fixed because it is exported on o_state for debug.
package rstseq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_SW_ASSERT = 3'd4
    } rstseq_state_e;

    // Width needed to count up to the largest of the three timing parameters.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// Lock qualifier: o_lock rises only after LOCK_FILTER consecutive i_lock==1
// samples and drops one cycle after any i_lock==0 sample.
// Only instantiated when RSTSEQ_LOCK_FILTER_EN is defined.
module rstseq_lock_filter #(
    parameter int LOCK_FILTER = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lock,
    output logic o_lock
);

    localparam int W = $clog2(LOCK_FILTER + 1);
    localparam logic [W-1:0] LAST = W'(LOCK_FILTER - 1);

    logic [W-1:0] cnt_r;
    logic         lock_r;

    // Saturating run-length counter of consecutive lock samples.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            cnt_r  <= {W{1'b0}};
            lock_r <= 1'b0;
        end else if (!i_lock) begin
            cnt_r  <= {W{1'b0}};
            lock_r <= 1'b0;
        end else if (cnt_r == LAST) begin
            cnt_r  <= cnt_r;
            lock_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + W'(1);
            lock_r <= lock_r;
        end
    end

    assign o_lock = lock_r;

endmodule

// File: rtl/reset_sequencer.sv
// Staged per-domain reset generator. Holds all domains in reset until lock,
// waits HOLD_CYCLES, then releases domains in ascending order every STAGE_GAP
// cycles. Lock loss or a software request re-asserts all domains.
// Optional lock qualification: define RSTSEQ_LOCK_FILTER_EN.
module reset_sequencer
    import rstseq_pkg::*;
#(
    parameter int N_DOMAINS     = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int STAGE_GAP     = 4,
    parameter int SW_MIN_CYCLES = 8,
    parameter int LOCK_FILTER   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_pll_lock,
    input  logic                 i_sw_rst_req,
    output logic [N_DOMAINS-1:0] o_rst_n,
    output logic [N_DOMAINS-1:0] o_rst,
    output logic                 o_done,
    output logic                 o_busy,
    output logic [2:0]           o_state
);

    localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, SW_MIN_CYCLES);
    localparam int IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] SW_LAST   = CNT_W'(SW_MIN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOMAINS - 1);

    if (N_DOMAINS < 1) begin : g_chk_domains
        $error("reset_sequencer: N_DOMAINS must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_sequencer: HOLD_CYCLES must be >= 1");
    end
    if (STAGE_GAP < 1) begin : g_chk_gap
        $error("reset_sequencer: STAGE_GAP must be >= 1");
    end
    if (SW_MIN_CYCLES < 1) begin : g_chk_sw
        $error("reset_sequencer: SW_MIN_CYCLES must be >= 1");
    end
    if (LOCK_FILTER < 1) begin : g_chk_filter
        $error("reset_sequencer: LOCK_FILTER must be >= 1");
    end

    logic lock_s;

`ifdef RSTSEQ_LOCK_FILTER_EN
    rstseq_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_lock (i_pll_lock),
        .o_lock (lock_s)
    );
`else
    assign lock_s = i_pll_lock;
`endif

    rstseq_state_e        state_r;
    logic [CNT_W-1:0]     cnt_r;
    logic [IDX_W-1:0]     idx_r;
    logic [N_DOMAINS-1:0] rst_n_r;
    logic                 done_r;
    logic                 busy_r;

    // Sequencer FSM: state, counters and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_WAIT_LOCK;
            cnt_r   <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            rst_n_r <= {N_DOMAINS{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_WAIT_LOCK: begin
                    cnt_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    rst_n_r <= {N_DOMAINS{1'b0}};
                    done_r  <= 1'b0;
                    busy_r  <= 1'b1;
                    if (lock_s) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= ST_WAIT_LOCK;
                    end
                end
                ST_HOLD: begin
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        rst_n_r <= {N_DOMAINS{1'b0}};
                    end else if (cnt_r == HOLD_LAST) begin
                        rst_n_r[0] <= 1'b1;
                        cnt_r      <= {CNT_W{1'b0}};
                        if (N_DOMAINS == 1) begin
                            // Single domain: releasing domain 0 completes the sequence.
                            state_r <= ST_RUN;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r <= ST_RELEASE;
                            idx_r   <= IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        rst_n_r <= {N_DOMAINS{1'b0}};
                    end else if (cnt_r == GAP_LAST) begin
                        rst_n_r[idx_r] <= 1'b1;
                        cnt_r          <= {CNT_W{1'b0}};
                        if (idx_r == IDX_LAST) begin
                            state_r <= ST_RUN;
                            done_r  <= 1'b1;
                            busy_r  <= 1'b0;
                        end else begin
                            idx_r <= idx_r + IDX_W'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    // Lock loss has priority over a simultaneous software request.
                    if (!lock_s) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        rst_n_r <= {N_DOMAINS{1'b0}};
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (i_sw_rst_req) begin
                        state_r <= ST_SW_ASSERT;
                        cnt_r   <= {CNT_W{1'b0}};
                        idx_r   <= {IDX_W{1'b0}};
                        rst_n_r <= {N_DOMAINS{1'b0}};
                        done_r  <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_SW_ASSERT: begin
                    // Lock is deliberately ignored here; this state always ends in WAIT_LOCK.
                    if (cnt_r == SW_LAST) begin
                        state_r <= ST_WAIT_LOCK;
                        cnt_r   <= {CNT_W{1'b0}};
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_WAIT_LOCK;
                    cnt_r   <= {CNT_W{1'b0}};
                    idx_r   <= {IDX_W{1'b0}};
                    rst_n_r <= {N_DOMAINS{1'b0}};
                    done_r  <= 1'b0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    // o_rst is a plain inversion of the registered o_rst_n, so both stay glitch-free.
    assign o_rst_n = rst_n_r;
    assign o_rst   = ~rst_n_r;
    assign o_done  = done_r;
    assign o_busy  = busy_r;
    assign o_state = state_r;

endmodule
